// File: rtl/cpu_wb_initiator.sv
// CPU-side Wishbone master: one LC-3b word/byte load or store becomes one
// 128-bit line transaction, with a watchdog that aborts a hung bus cycle.
module cpu_wb_initiator #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [1:0]   mem_byte_enable,
  input  logic [15:0]  mem_address,
  input  logic [15:0]  mem_wdata,
  output logic         mem_resp,
  output logic [15:0]  mem_rdata,
  output logic         mem_err,
  output logic         wb_cyc,
  output logic         wb_stb,
  output logic         wb_we,
  output logic [15:0]  wb_sel,
  output logic [11:0]  wb_adr,
  output logic [127:0] wb_dat_m,
  input  logic [127:0] wb_dat_s,
  input  logic         wb_ack,
  input  logic         wb_rty
);

  localparam int unsigned WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t         state, state_next;
  logic [15:1]    addr;
  logic [15:0]    wdata;
  logic [1:0]     be;
  logic           we;
  logic [15:0]    rdata;
  logic           err;
  logic [WDW-1:0] wd;
  logic           timeout;
  logic           unused_addr_bit0;

  assign unused_addr_bit0 = mem_address[0];

  // The counter holds the number of BUS cycles already spent without ACK,
  // so the abort decision is taken in the TIMEOUT-th such cycle.
  assign timeout = (TIMEOUT != 0) && (32'(wd) == TIMEOUT - 1);

  assign wb_we     = we;
  assign wb_adr    = addr[15:4];
  assign wb_dat_m  = {8{wdata}};
  assign mem_rdata = rdata;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    wb_cyc     = 1'b0;
    wb_stb     = 1'b0;
    wb_sel     = '0;
    mem_resp   = 1'b0;
    mem_err    = 1'b0;
    case (state)
      IDLE: begin
        if (mem_read || mem_write) state_next = BUS;
      end
      BUS: begin
        wb_cyc = 1'b1;
        wb_stb = 1'b1;
        wb_sel = we ? (16'(be) << {addr[3:1], 1'b0}) : '1;
        if (wb_ack || timeout) state_next = RESP;
      end
      RESP: begin
        mem_resp   = 1'b1;
        mem_err    = err;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr  <= '0;
      wdata <= '0;
      be    <= '0;
      we    <= 1'b0;
      rdata <= '0;
      err   <= 1'b0;
      wd    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_read || mem_write) begin
            addr  <= mem_address[15:1];
            wdata <= mem_wdata;
            be    <= mem_byte_enable;
            we    <= mem_write;
            err   <= 1'b0;
            wd    <= '0;
          end
        end
        BUS: begin
          if (wb_ack) begin
            rdata <= wb_dat_s[{addr[3:1], 4'b0000} +: 16];
          end else if (timeout) begin
            err   <= 1'b1;
            rdata <= '0;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_wb_initiator.sv
// Scoreboard bench for cpu_wb_initiator: CPU tasks push expected responses,
// a monitor pops them on mem_resp; a simple slave answers with RTY/ACK.
module tb_cpu_wb_initiator;

  logic         clk = 1'b0;
  logic         rst;
  logic         mem_read, mem_write;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  mem_address, mem_wdata;
  logic         mem_resp, mem_err;
  logic [15:0]  mem_rdata;
  logic         wb_cyc, wb_stb, wb_we;
  logic [15:0]  wb_sel;
  logic [11:0]  wb_adr;
  logic [127:0] wb_dat_m, wb_dat_s;
  logic         wb_ack, wb_rty;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        chk_rd;
    logic [15:0] rd;
    logic        err;
  } exp_t;
  exp_t sb[$];

  int rty_n     = 0;
  bit never_ack = 1'b0;

  cpu_wb_initiator #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .mem_err(mem_err), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
    .wb_sel(wb_sel), .wb_adr(wb_adr), .wb_dat_m(wb_dat_m),
    .wb_dat_s(wb_dat_s), .wb_ack(wb_ack), .wb_rty(wb_rty)
  );

  initial forever #5 clk = ~clk;

  // Slave: decides ACK/RTY at the falling edge for the next rising edge.
  initial begin
    int rcnt;
    rcnt   = 0;
    wb_ack = 1'b0;
    wb_rty = 1'b0;
    forever begin
      @(negedge clk);
      if (wb_cyc === 1'b1 && wb_stb === 1'b1) begin
        if (never_ack) begin
          wb_ack = 1'b0; wb_rty = 1'b1;
        end else if (rcnt < rty_n) begin
          wb_ack = 1'b0; wb_rty = 1'b1; rcnt++;
        end else begin
          wb_ack = 1'b1; wb_rty = 1'b0;
        end
      end else begin
        wb_ack = 1'b0; wb_rty = 1'b0; rcnt = 0;
      end
    end
  end

  // Response monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mem_resp === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL resp_unexpected: got mem_resp=1 err=%b rdata=%h, required no response", mem_err, mem_rdata);
        end else begin
          e = sb.pop_front();
          if (mem_err !== e.err) begin
            failures++;
            $display("FAIL resp_err: got %b, required %b", mem_err, e.err);
          end
          if (e.chk_rd) begin
            checks++;
            if (mem_rdata !== e.rd) begin
              failures++;
              $display("FAIL resp_rdata: got %h, required %h", mem_rdata, e.rd);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "global timeout");
  end

  // Called at a falling edge in IDLE; returns at the falling edge after RESP.
  task automatic do_req(input logic rd, input logic wr, input logic [1:0] be,
                        input logic [15:0] a, input logic [15:0] wd,
                        input logic chk_rd, input logic [15:0] erd, input logic eerr,
                        input logic [11:0] eadr, input logic [15:0] esel, input logic ewe,
                        input int elat, input int ecyc, input string name);
    int n, cyc_n;
    bit done;
    checks++;
    if (wb_cyc !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle_before: cyc=%b, required 0", name, wb_cyc);
    end
    mem_read = rd; mem_write = wr; mem_byte_enable = be;
    mem_address = a; mem_wdata = wd;
    sb.push_back('{chk_rd, erd, eerr});
    n = 0; cyc_n = 0; done = 1'b0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      if (wb_cyc === 1'b1) begin
        cyc_n++;
        checks++;
        if ({wb_stb, wb_we, wb_adr, wb_sel} !== {1'b1, ewe, eadr, esel} || wb_dat_m !== {8{wd}}) begin
          failures++;
          $display("FAIL %s_bus: stb=%b we=%b adr=%h sel=%h dat_m=%h, required stb=1 we=%b adr=%h sel=%h dat_m=%h",
                   name, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_m, ewe, eadr, esel, {8{wd}});
        end
      end
      if (mem_resp === 1'b1) begin
        done = 1'b1;
        checks++;
        if (n !== elat) begin
          failures++;
          $display("FAIL %s_latency: got %0d cycles, required %0d", name, n, elat);
        end
        checks++;
        if (cyc_n !== ecyc) begin
          failures++;
          $display("FAIL %s_cyc_len: got %0d cycles, required %0d", name, cyc_n, ecyc);
        end
        checks++;
        if (wb_cyc !== 1'b0 || wb_stb !== 1'b0) begin
          failures++;
          $display("FAIL %s_cyc_in_resp: cyc=%b stb=%b, required 0 0", name, wb_cyc, wb_stb);
        end
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL %s_no_resp: no mem_resp within 40 cycles, required a response", name);
    end
    mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_resp !== 1'b0 || wb_cyc !== 1'b0) begin
      failures++;
      $display("FAIL %s_after: resp=%b cyc=%b, required 0 0", name, mem_resp, wb_cyc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; mem_byte_enable = '0;
    mem_address = '0; mem_wdata = '0;
    for (int i = 0; i < 8; i++) wb_dat_s[16*i +: 16] = 16'h1000 + 16'(i);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, mem_resp, mem_err, mem_rdata} !== '0 || wb_dat_m !== '0) begin
      failures++;
      $display("FAIL reset_values: cyc=%b stb=%b we=%b sel=%h adr=%h dat_m=%h resp=%b err=%b rdata=%h, required all 0",
               wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_m, mem_resp, mem_err, mem_rdata);
    end
  endtask

  task automatic test_load_rty();
    wb_dat_s[48 +: 16] = 16'hBEEF;
    rty_n = 3;
    do_req(1'b1, 1'b0, 2'b00, 16'h1236, 16'h0000, 1'b1, 16'hBEEF, 1'b0,
           12'h123, 16'hFFFF, 1'b0, 5, 4, "load_rty");
    rty_n = 0;
  endtask

  task automatic test_store();
    do_req(1'b0, 1'b1, 2'b10, 16'h004E, 16'hA55A, 1'b0, 16'h0000, 1'b0,
           12'h004, 16'h8000, 1'b1, 2, 1, "store");
    do_req(1'b0, 1'b1, 2'b00, 16'h0002, 16'h5555, 1'b0, 16'h0000, 1'b0,
           12'h000, 16'h0000, 1'b1, 2, 1, "store_be0");
  endtask

  task automatic test_both_high();
    do_req(1'b1, 1'b1, 2'b11, 16'h0000, 16'h1234, 1'b0, 16'h0000, 1'b0,
           12'h000, 16'h0003, 1'b1, 2, 1, "both_high");
  endtask

  task automatic test_timeout();
    never_ack = 1'b1;
    do_req(1'b1, 1'b0, 2'b00, 16'h0010, 16'h0000, 1'b1, 16'h0000, 1'b1,
           12'h001, 16'hFFFF, 1'b0, 5, 4, "timeout");
    never_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    never_ack = 1'b1;
    mem_read = 1'b1; mem_address = 16'h0020; mem_wdata = 16'h0000;
    @(negedge clk);
    checks++;
    if (wb_cyc !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_cyc_rise: cyc=%b, required 1", wb_cyc);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (wb_cyc !== 1'b0 || wb_stb !== 1'b0 || mem_resp !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_drop: cyc=%b stb=%b resp=%b, required 0 0 0", wb_cyc, wb_stb, mem_resp);
    end
    rst = 1'b0; mem_read = 1'b0; never_ack = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (mem_rdata !== 16'h0000 || mem_err !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_state: rdata=%h err=%b, required 0000 0", mem_rdata, mem_err);
    end
    do_req(1'b1, 1'b0, 2'b00, 16'h1232, 16'h0000, 1'b1, 16'h1001, 1'b0,
           12'h123, 16'hFFFF, 1'b0, 2, 1, "after_reset");
  endtask

  task automatic test_back_to_back();
    do_req(1'b1, 1'b0, 2'b00, 16'h0004, 16'h0000, 1'b1, 16'h1002, 1'b0,
           12'h000, 16'hFFFF, 1'b0, 2, 1, "b2b_first");
    do_req(1'b1, 1'b0, 2'b00, 16'h000E, 16'h0000, 1'b1, 16'h1007, 1'b0,
           12'h000, 16'hFFFF, 1'b0, 2, 1, "b2b_second");
  endtask

  initial begin
    test_reset();
    test_load_rty();
    test_store();
    test_both_high();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
